// File: rtl/sw_seq_feeder_pkg.sv
// Shared constants and state encoding for the Smith-Waterman host feeder.
// The systolic core's top level uses the same symbol and score widths.
package sw_seq_feeder_pkg;

  localparam int SYM_W       = 2;
  localparam int SCORE_W     = 12;
  localparam int SEQ_LEN_DEF = 256;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_WAIT   = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

endpackage

// File: rtl/sw_seq_mem.sv
// Query (S) and target (T) symbol stores: one write port each, shared
// combinational read index; the feeder registers the read data.
module sw_seq_mem
  import sw_seq_feeder_pkg::*;
#(
  parameter int SEQ_LEN = SEQ_LEN_DEF,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SYM_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [SYM_W-1:0]  rd_s,
  output logic [SYM_W-1:0]  rd_t
);

  logic [SYM_W-1:0] mem_s [SEQ_LEN];
  logic [SYM_W-1:0] mem_t [SEQ_LEN];

  // Contents are deliberately not reset; the host reloads as needed.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_sel) mem_s[wr_addr] <= wr_data;
    if (wr_en && wr_sel)  mem_t[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_s = '0;
    rd_t = '0;
    if (int'(rd_addr) < SEQ_LEN) begin
      rd_s = mem_s[rd_addr];
      rd_t = mem_t[rd_addr];
    end
  end

endmodule

// File: rtl/sw_seq_feeder.sv
// Host-side source/collector for the Smith-Waterman core: streams S and T as
// one contiguous valid burst, then captures the core's max score or times out.
//
// state  | meaning
// IDLE   | host may write symbols; waits for start
// STREAM | valid burst, one S/T symbol pair per cycle
// WAIT   | waits for finish from the core, bounded by TIMEOUT cycles
// DONE   | one-cycle done pulse, busy drops on exit
module sw_seq_feeder
  import sw_seq_feeder_pkg::*;
#(
  parameter int SEQ_LEN = SEQ_LEN_DEF,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [SYM_W-1:0]   wr_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic               timeout,
  output logic               valid,
  output logic [SYM_W-1:0]   data_s,
  output logic [SYM_W-1:0]   data_t,
  input  logic               finish,
  input  logic [SCORE_W-1:0] max
);

  localparam int IDX_W  = ADDR_W + 1;
  localparam int WCNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [IDX_W-1:0]  IDX_LEN   = IDX_W'(SEQ_LEN);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SEQ_LEN - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [WCNT_W-1:0]  wcnt, wcnt_nxt;
  logic               busy_nxt, done_nxt, valid_nxt, timeout_nxt;
  logic [SYM_W-1:0]   data_s_nxt, data_t_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic [ADDR_W-1:0]  rd_addr;
  logic [SYM_W-1:0]   rd_s, rd_t;
  logic               mem_wr;

  // start wins over a same-cycle write, keeping the burst source stable.
  assign mem_wr = wr_en && !start && (state == ST_IDLE) && ({1'b0, wr_addr} < IDX_LEN);

  sw_seq_mem #(
    .SEQ_LEN (SEQ_LEN),
    .ADDR_W  (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_wr),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_s    (rd_s),
    .rd_t    (rd_t)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      wcnt    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
      data_s  <= '0;
      data_t  <= '0;
      score   <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      wcnt    <= wcnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      valid   <= valid_nxt;
      data_s  <= data_s_nxt;
      data_t  <= data_t_nxt;
      score   <= score_nxt;
      timeout <= timeout_nxt;
    end
  end

  // idx tracks the symbol currently on the outputs; the read port looks one ahead.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    wcnt_nxt    = wcnt;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    valid_nxt   = 1'b0;
    data_s_nxt  = '0;
    data_t_nxt  = '0;
    score_nxt   = score;
    timeout_nxt = timeout;
    rd_addr     = idx[ADDR_W-1:0] + 1'b1;
    case (state)
      ST_IDLE: begin
        rd_addr = '0;
        if (start) begin
          state_nxt   = ST_STREAM;
          busy_nxt    = 1'b1;
          timeout_nxt = 1'b0;
          score_nxt   = '0;
          idx_nxt     = '0;
          valid_nxt   = 1'b1;
          data_s_nxt  = rd_s;
          data_t_nxt  = rd_t;
        end
      end
      ST_STREAM: begin
        if (idx == IDX_LAST) begin
          state_nxt = ST_WAIT;
          wcnt_nxt  = '0;
        end else begin
          idx_nxt    = idx + 1'b1;
          valid_nxt  = 1'b1;
          data_s_nxt = rd_s;
          data_t_nxt = rd_t;
        end
      end
      ST_WAIT: begin
        if (finish) begin
          state_nxt = ST_DONE;
          score_nxt = max;
          done_nxt  = 1'b1;
        end else if (wcnt == WCNT_LAST) begin
          state_nxt   = ST_DONE;
          timeout_nxt = 1'b1;
          done_nxt    = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Directed bench for sw_seq_feeder: burst content/timing, finish capture,
// timeout, write/start lockout while busy, reset mid-burst, finish at the limit.
module tb_sw_seq_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        wr_sel;
  logic [7:0]  wr_addr;
  logic [1:0]  wr_data;
  logic        start;
  logic        busy;
  logic        done;
  logic [11:0] score;
  logic        timeout;
  logic        valid;
  logic [1:0]  data_s;
  logic [1:0]  data_t;
  logic        finish;
  logic [11:0] max;

  int n_cmp = 0;
  int n_bad = 0;

  sw_seq_feeder dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .score   (score),
    .timeout (timeout),
    .valid   (valid),
    .data_s  (data_s),
    .data_t  (data_t),
    .finish  (finish),
    .max     (max)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic load_pattern();
    for (int k = 0; k < 256; k++) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'(k); wr_data = 2'(k % 4);
      cyc();
      wr_sel = 1'b1; wr_data = 2'((k + 1) % 4);
      cyc();
    end
    wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, valid, timeout} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, valid, timeout});
    end
    n_cmp++;
    if ({data_s, data_t} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_data: got s=%0d t=%0d want 0 0", data_s, data_t);
    end
    n_cmp++;
    if (score !== 12'd0) begin
      n_bad++; $display("FAIL reset_score: got %0d want 0", score);
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_burst();
    logic [1:0] es, et;
    bit early;
    pulse_start();
    for (int k = 0; k < 256; k++) begin
      es = 2'(k % 4); et = 2'((k + 1) % 4);
      n_cmp++;
      if ({valid, data_s, data_t} !== {1'b1, es, et}) begin
        n_bad++;
        $display("FAIL burst_k%0d: got v=%b s=%0d t=%0d want v=1 s=%0d t=%0d", k, valid, data_s, data_t, es, et);
      end
      // finish during the stream must be ignored
      finish = (k == 50);
      max    = (k == 50) ? 12'd99 : 12'd0;
      cyc();
    end
    finish = 1'b0; max = '0;
    n_cmp++;
    if ({valid, data_s, data_t, busy, done} !== {1'b0, 2'd0, 2'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL post_burst: got v=%b s=%0d t=%0d busy=%b done=%b want 0 0 0 1 0", valid, data_s, data_t, busy, done);
    end
    early = 1'b0;
    repeat (9) begin
      if (done) early = 1'b1;
      cyc();
    end
    finish = 1'b1; max = 12'd517;
    cyc();
    finish = 1'b0; max = '0;
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++; $display("FAIL finish_early_done: got done before finish, want none");
    end
    n_cmp++;
    if ({done, busy, timeout, score} !== {1'b1, 1'b1, 1'b0, 12'd517}) begin
      n_bad++;
      $display("FAIL finish_capture: got done=%b busy=%b to=%b score=%0d want 1 1 0 517", done, busy, timeout, score);
    end
    // start during DONE must be ignored
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_cmp++;
    if ({done, busy, valid, score} !== {1'b0, 1'b0, 1'b0, 12'd517}) begin
      n_bad++;
      $display("FAIL done_exit: got done=%b busy=%b v=%b score=%0d want 0 0 0 517", done, busy, valid, score);
    end
    cyc();
  endtask

  task automatic test_timeout();
    bit early;
    pulse_start();
    n_cmp++;
    if ({score, timeout} !== {12'd0, 1'b0}) begin
      n_bad++; $display("FAIL start_clears_score: got score=%0d to=%b want 0 0", score, timeout);
    end
    repeat (256) cyc();
    early = 1'b0;
    repeat (1023) begin
      if (done) early = 1'b1;
      cyc();
    end
    if (done) early = 1'b1;
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++; $display("FAIL timeout_early: got done before 1024 wait cycles, want none");
    end
    cyc();
    n_cmp++;
    if ({done, timeout, score, busy} !== {1'b1, 1'b1, 12'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL timeout_done: got done=%b to=%b score=%0d busy=%b want 1 1 0 1", done, timeout, score, busy);
    end
    cyc();
    n_cmp++;
    if ({done, timeout, busy} !== {1'b0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL timeout_sticky: got done=%b to=%b busy=%b want 0 1 0", done, timeout, busy);
    end
    cyc();
  endtask

  task automatic test_busy_write();
    logic [1:0] es, et;
    pulse_start();
    n_cmp++;
    if ({timeout, busy} !== {1'b0, 1'b1}) begin
      n_bad++; $display("FAIL start_clears_timeout: got to=%b busy=%b want 0 1", timeout, busy);
    end
    for (int k = 0; k < 256; k++) begin
      es = 2'(k % 4); et = 2'((k + 1) % 4);
      n_cmp++;
      if ({valid, data_s, data_t} !== {1'b1, es, et}) begin
        n_bad++;
        $display("FAIL busy_burst_k%0d: got v=%b s=%0d t=%0d want v=1 s=%0d t=%0d", k, valid, data_s, data_t, es, et);
      end
      wr_en   = (k == 3);
      wr_sel  = 1'b0;
      wr_addr = 8'd5;
      wr_data = 2'b11;
      start   = (k == 10);
      cyc();
    end
    wr_en = 1'b0; start = 1'b0;
    n_cmp++;
    if ({valid, busy} !== {1'b0, 1'b1}) begin
      n_bad++; $display("FAIL busy_no_restart: got v=%b busy=%b want 0 1", valid, busy);
    end
    finish = 1'b1; max = 12'd7;
    cyc();
    finish = 1'b0; max = '0;
    n_cmp++;
    if ({done, score} !== {1'b1, 12'd7}) begin
      n_bad++; $display("FAIL busy_run_done: got done=%b score=%0d want 1 7", done, score);
    end
    repeat (2) cyc();
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] es, et;
    bit seen_done;
    pulse_start();
    repeat (100) cyc();
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({valid, busy, data_s, data_t} !== 6'b0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b busy=%b s=%0d t=%0d want 0 0 0 0", valid, busy, data_s, data_t);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    seen_done = 1'b0;
    repeat (20) begin
      if (done || busy || valid) seen_done = 1'b1;
      cyc();
    end
    n_cmp++;
    if (seen_done !== 1'b0) begin
      n_bad++; $display("FAIL reset_no_done: got activity after reset, want idle");
    end
    pulse_start();
    for (int k = 0; k < 256; k++) begin
      es = 2'(k % 4); et = 2'((k + 1) % 4);
      n_cmp++;
      if ({valid, data_s, data_t} !== {1'b1, es, et}) begin
        n_bad++;
        $display("FAIL rst_burst_k%0d: got v=%b s=%0d t=%0d want v=1 s=%0d t=%0d", k, valid, data_s, data_t, es, et);
      end
      cyc();
    end
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_burst_end: got v=%b want 0", valid);
    end
    finish = 1'b1; max = 12'd1;
    cyc();
    finish = 1'b0; max = '0;
    repeat (2) cyc();
  endtask

  task automatic test_finish_at_limit();
    logic [1:0] es, et;
    // same-cycle write to S[0] must be dropped in favour of start
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd0; wr_data = 2'b11;
    pulse_start();
    wr_en = 1'b0;
    for (int k = 0; k < 256; k++) begin
      es = 2'(k % 4); et = 2'((k + 1) % 4);
      n_cmp++;
      if ({valid, data_s, data_t} !== {1'b1, es, et}) begin
        n_bad++;
        $display("FAIL lim_burst_k%0d: got v=%b s=%0d t=%0d want v=1 s=%0d t=%0d", k, valid, data_s, data_t, es, et);
      end
      cyc();
    end
    repeat (1023) cyc();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL lim_pre_done: got done=%b want 0", done);
    end
    finish = 1'b1; max = 12'd42;
    cyc();
    finish = 1'b0; max = '0;
    n_cmp++;
    if ({done, timeout, score} !== {1'b1, 1'b0, 12'd42}) begin
      n_bad++; $display("FAIL lim_finish_wins: got done=%b to=%b score=%0d want 1 0 42", done, timeout, score);
    end
    cyc();
    n_cmp++;
    if ({done, timeout, busy, score} !== {1'b0, 1'b0, 1'b0, 12'd42}) begin
      n_bad++;
      $display("FAIL lim_single_done: got done=%b to=%b busy=%b score=%0d want 0 0 0 42", done, timeout, busy, score);
    end
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; finish = 1'b0; max = '0;
    test_reset();
    load_pattern();
    test_burst();
    test_timeout();
    test_busy_write();
    test_reset_mid_burst();
    test_finish_at_limit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion within 500000 ns, want finish");
    $fatal(1);
  end

endmodule
